paper_cpu: RTL

Parametrised successor to the 2-bit paper processor. It is a multi-cycle accumulator machine with a loadable program memory, a sticky overflow flag and a fetch/execute state machine. Width and depth are generic. It adds a CLR instruction and a start/halt handshake so the bench or a host can reload and rerun programs without a reset.

---
 rtl/paper_cpu.sv | 111 +++++++++++
 1 files changed

// File: rtl/paper_cpu.sv
// paper_cpu: parametrised multi-cycle accumulator machine.
// Loadable program memory, sticky overflow, start/halt handshake.
module paper_cpu #(
  parameter int DW = 4,
  parameter int AW = 3,
  localparam int IW = 2 + AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          start,
  output logic [DW-1:0] acc,
  output logic [AW-1:0] pc,
  output logic          ovf,
  output logic          busy,
  output logic          halted
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    HALT
  } state_t;

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_JNO = 2'b01;
  localparam logic [1:0] OP_HLT = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] ir;
  logic [IW-1:0] mem [2**AW];
  logic [1:0]    op;
  logic [AW-1:0] tgt;
  logic          stopped;

  assign op      = ir[IW-1 -: 2];
  assign tgt     = ir[AW-1:0];
  assign stopped = (state == IDLE) || (state == HALT);

  // Status outputs decoded from the state register only.
  assign busy   = (state == FETCH) || (state == EXEC);
  assign halted = (state == HALT);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; start only matters when not busy.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: state_nxt = EXEC;
      EXEC:  state_nxt = (op == OP_HLT) ? HALT : FETCH;
      HALT:  if (start) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Program memory; not reset, writable only when stopped.
  always_ff @(posedge clk) begin
    if (prog_we && stopped) mem[prog_addr] <= prog_data;
  end

  // Datapath: launch clears, fetch, and execute.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      pc  <= '0;
      ovf <= 1'b0;
      ir  <= '0;
    end else begin
      unique case (state)
        IDLE, HALT: begin
          if (start) begin
            acc <= '0;
            pc  <= '0;
            ovf <= 1'b0;
          end
        end
        FETCH: ir <= mem[pc];
        EXEC: begin
          unique case (op)
            OP_INC: begin
              acc <= acc + DW'(1);
              if (&acc) ovf <= 1'b1;
              pc  <= pc + AW'(1);
            end
            OP_JNO: pc <= ovf ? pc + AW'(1) : tgt;
            OP_HLT: pc <= pc;
            OP_CLR: begin
              acc <= '0;
              ovf <= 1'b0;
              pc  <= pc + AW'(1);
            end
            default: pc <= pc;
          endcase
        end
        default: pc <= pc;
      endcase
    end
  end

endmodule
